// File: rtl/fml_mem_txn_capture_if.sv
// Memory bus observation interface for fml_mem_txn_capture.
//   mem_req/mem_gnt        : request handshake, accepted when both high
//   mem_wen/addr/wdata/ben : request attributes, valid at acceptance
//   mem_rvalid/rdata/error : response strobe, read data, bus error
// master drives the bus; slave observes it (the capture block is a pure monitor).
interface fml_mem_txn_capture_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic          mem_req;
  logic          mem_gnt;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_ben;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          mem_error;

  modport master (
    output mem_req, mem_gnt, mem_wen, mem_addr, mem_wdata, mem_ben,
           mem_rvalid, mem_rdata, mem_error
  );

  modport slave (
    input mem_req, mem_gnt, mem_wen, mem_addr, mem_wdata, mem_ben,
          mem_rvalid, mem_rdata, mem_error
  );
endinterface

// File: rtl/fml_mem_txn_capture.sv
// Captures the memory transactions issued during one retired instruction.
// Each accepted request is held until its response, then committed into a
// working buffer slot. A retire strobe (vtx_valid) copies the working buffer
// to the registered snapshot outputs and starts a fresh window.
//   vtx_clk, vtx_resetn : clock, asynchronous active-low reset
//   mem                 : observed memory bus (slave modport)
//   vtx_valid           : instruction retire strobe, closes the window
//   vtx_out_valid       : one-cycle pulse, snapshot outputs just updated
//   vtx_mem_*           : per-slot snapshot, slot i at [i*W +: W]
//   vtx_txn_count       : transactions in the snapshot
//   vtx_txn_ovf         : window saw more than NTXN transactions
//   vtx_proto_err       : sticky bus protocol violation
module fml_mem_txn_capture #(
  parameter int NTXN = 4,
  parameter int AW   = 32,
  parameter int DW   = 32,
  localparam int BW  = DW / 8,
  localparam int CW  = $clog2(NTXN + 1)
) (
  input  logic                 vtx_clk,
  input  logic                 vtx_resetn,
  fml_mem_txn_capture_if.slave mem,
  input  logic                 vtx_valid,
  output logic                 vtx_out_valid,
  output logic [NTXN-1:0]      vtx_mem_cen,
  output logic [NTXN-1:0]      vtx_mem_wen,
  output logic [NTXN-1:0]      vtx_mem_error,
  output logic [NTXN*AW-1:0]   vtx_mem_addr,
  output logic [NTXN*DW-1:0]   vtx_mem_wdata,
  output logic [NTXN*DW-1:0]   vtx_mem_rdata,
  output logic [NTXN*BW-1:0]   vtx_mem_ben,
  output logic [CW-1:0]        vtx_txn_count,
  output logic                 vtx_txn_ovf,
  output logic                 vtx_proto_err
);

  typedef enum logic { IDLE, WAIT_RSP } state_e;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] ben;
  } pend_t;

  // Same layout is used for the working buffer and the snapshot so a retire
  // is a single struct copy.
  typedef struct packed {
    logic [NTXN-1:0]    cen;
    logic [NTXN-1:0]    wen;
    logic [NTXN-1:0]    err;
    logic [NTXN*AW-1:0] addr;
    logic [NTXN*DW-1:0] wdata;
    logic [NTXN*DW-1:0] rdata;
    logic [NTXN*BW-1:0] ben;
    logic [CW-1:0]      count;
    logic               ovf;
  } buf_t;

  state_e state_q, state_d;
  pend_t  pend_q, pend_d, pend_new;
  buf_t   wbuf_q, wbuf_d, wbuf_post;
  buf_t   snap_q, snap_d;
  logic   out_valid_q, out_valid_d;
  logic   proto_err_q, proto_err_d;
  logic   accept, commit;

  assign accept = mem.mem_req && mem.mem_gnt;
  assign commit = (state_q == WAIT_RSP) && mem.mem_rvalid;

  assign pend_new = '{wen: mem.mem_wen, addr: mem.mem_addr,
                      wdata: mem.mem_wdata, ben: mem.mem_ben};

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pend_d      = pend_q;
    proto_err_d = proto_err_q;
    wbuf_post   = wbuf_q;
    snap_d      = snap_q;
    out_valid_d = vtx_valid;

    unique case (state_q)
      IDLE: begin
        if (mem.mem_rvalid) proto_err_d = 1'b1;   // response with nothing outstanding
        if (accept) begin
          pend_d  = pend_new;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem.mem_rvalid) begin
          if (accept) pend_d  = pend_new;         // pipelined back-to-back request
          else        state_d = IDLE;
        end else if (accept) begin
          proto_err_d = 1'b1;                     // second request while one is outstanding
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      if (wbuf_q.count == CW'(NTXN)) begin
        wbuf_post.ovf = 1'b1;
      end else begin
        for (int i = 0; i < NTXN; i++) begin
          if (wbuf_q.count == CW'(i)) begin
            wbuf_post.cen[i]              = 1'b1;
            wbuf_post.wen[i]              = pend_q.wen;
            wbuf_post.err[i]              = mem.mem_error;
            wbuf_post.addr[i*AW +: AW]    = pend_q.addr;
            wbuf_post.wdata[i*DW +: DW]   = pend_q.wdata;
            wbuf_post.rdata[i*DW +: DW]   = mem.mem_rdata;
            wbuf_post.ben[i*BW +: BW]     = pend_q.ben;
          end
        end
        wbuf_post.count = wbuf_q.count + CW'(1);
      end
    end

    // A commit in the retire cycle itself still lands in this snapshot;
    // the pending transaction (if any) carries into the next window.
    wbuf_d = wbuf_post;
    if (vtx_valid) begin
      snap_d = wbuf_post;
      wbuf_d = '0;
    end
  end

  // NOTE: the capture buffers are reset along with the control state because
  // a reset must zero every output immediately and discard partial windows.
  always_ff @(posedge vtx_clk or negedge vtx_resetn) begin
    if (!vtx_resetn) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      wbuf_q      <= '0;
      snap_q      <= '0;
      out_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      pend_q      <= pend_d;
      wbuf_q      <= wbuf_d;
      snap_q      <= snap_d;
      out_valid_q <= out_valid_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign vtx_out_valid = out_valid_q;
  assign vtx_mem_cen   = snap_q.cen;
  assign vtx_mem_wen   = snap_q.wen;
  assign vtx_mem_error = snap_q.err;
  assign vtx_mem_addr  = snap_q.addr;
  assign vtx_mem_wdata = snap_q.wdata;
  assign vtx_mem_rdata = snap_q.rdata;
  assign vtx_mem_ben   = snap_q.ben;
  assign vtx_txn_count = snap_q.count;
  assign vtx_txn_ovf   = snap_q.ovf;
  assign vtx_proto_err = proto_err_q;

endmodule

// File: tb/tb_fml_mem_txn_capture.sv
module tb_fml_mem_txn_capture;
  localparam int NTXN = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int CW   = $clog2(NTXN + 1);

  logic               vtx_clk;
  logic               vtx_resetn;
  logic               vtx_valid;
  logic               vtx_out_valid;
  logic [NTXN-1:0]    vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
  logic [NTXN*AW-1:0] vtx_mem_addr;
  logic [NTXN*DW-1:0] vtx_mem_wdata, vtx_mem_rdata;
  logic [NTXN*BW-1:0] vtx_mem_ben;
  logic [CW-1:0]      vtx_txn_count;
  logic               vtx_txn_ovf;
  logic               vtx_proto_err;

  int n_checks = 0;
  int n_err    = 0;

  fml_mem_txn_capture_if #(.AW(AW), .DW(DW)) bus ();

  fml_mem_txn_capture #(.NTXN(NTXN), .AW(AW), .DW(DW)) dut (
    .vtx_clk       (vtx_clk),
    .vtx_resetn    (vtx_resetn),
    .mem           (bus),
    .vtx_valid     (vtx_valid),
    .vtx_out_valid (vtx_out_valid),
    .vtx_mem_cen   (vtx_mem_cen),
    .vtx_mem_wen   (vtx_mem_wen),
    .vtx_mem_error (vtx_mem_error),
    .vtx_mem_addr  (vtx_mem_addr),
    .vtx_mem_wdata (vtx_mem_wdata),
    .vtx_mem_rdata (vtx_mem_rdata),
    .vtx_mem_ben   (vtx_mem_ben),
    .vtx_txn_count (vtx_txn_count),
    .vtx_txn_ovf   (vtx_txn_ovf),
    .vtx_proto_err (vtx_proto_err)
  );

  initial vtx_clk = 1'b0;
  always #5 vtx_clk = ~vtx_clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.mem_req    = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_ben    = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_error  = 1'b0;
    vtx_valid      = 1'b0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge vtx_clk);
    #1;
    clr();
  endtask

  task automatic req(input logic wen, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [BW-1:0] ben);
    bus.mem_req   = 1'b1;
    bus.mem_gnt   = 1'b1;
    bus.mem_wen   = wen;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_ben   = ben;
  endtask

  task automatic rsp(input logic [DW-1:0] rdata, input logic err);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    bus.mem_error  = err;
  endtask

  task automatic reset_pulse();
    vtx_resetn = 1'b0;
    step();
    vtx_resetn = 1'b1;
    step();
  endtask

  initial begin
    clr();
    vtx_resetn = 1'b0;
    #1;
    check("rst_out_valid", vtx_out_valid, 0);
    check("rst_count",     vtx_txn_count, 0);
    check("rst_cen",       vtx_mem_cen,   0);
    check("rst_proto",     vtx_proto_err, 0);
    step();
    vtx_resetn = 1'b1;
    step();

    // Single write, response two cycles after acceptance.
    req(1'b1, 32'h100, 32'hA5A5_A5A5, 4'hF); step();
    step();
    rsp(32'h0, 1'b0); step();
    vtx_valid = 1'b1; step();
    check("w1_out_valid", vtx_out_valid, 1);
    check("w1_count",     vtx_txn_count, 1);
    check("w1_cen",       vtx_mem_cen,   4'b0001);
    check("w1_wen",       vtx_mem_wen,   4'b0001);
    check("w1_addr",      vtx_mem_addr,  32'h100);
    check("w1_wdata",     vtx_mem_wdata, 32'hA5A5_A5A5);
    check("w1_ben",       vtx_mem_ben,   4'hF);
    check("w1_ovf",       vtx_txn_ovf,   0);
    step();
    check("w1_pulse_end", vtx_out_valid, 0);
    check("w1_hold",      vtx_txn_count, 1);

    // Six reads overflow a four-slot window; second one reports a bus error.
    for (int k = 1; k <= 6; k++) begin
      req(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF); step();
      rsp(32'(k), k == 2); step();
    end
    vtx_valid = 1'b1; step();
    check("ovf_count", vtx_txn_count, 4);
    check("ovf_flag",  vtx_txn_ovf,   1);
    check("ovf_rdata", vtx_mem_rdata, {32'd4, 32'd3, 32'd2, 32'd1});
    check("ovf_addr",  vtx_mem_addr,  {32'h210, 32'h20C, 32'h208, 32'h204});
    check("ovf_cen",   vtx_mem_cen,   4'b1111);
    check("ovf_wen",   vtx_mem_wen,   4'b0000);
    check("ovf_err",   vtx_mem_error, 4'b0010);

    // Pipelined accept with response; retire in the second response cycle.
    req(1'b0, 32'h10, 32'h0, 4'h3); step();
    rsp(32'hAA, 1'b0); req(1'b0, 32'h14, 32'h0, 4'hC); step();
    rsp(32'hBB, 1'b0); vtx_valid = 1'b1; step();
    check("pipe_count", vtx_txn_count, 2);
    check("pipe_addr",  vtx_mem_addr,  {64'h0, 32'h14, 32'h10});
    check("pipe_rdata", vtx_mem_rdata, {64'h0, 32'hBB, 32'hAA});
    check("pipe_ben",   vtx_mem_ben,   16'h00C3);
    check("pipe_ovf",   vtx_txn_ovf,   0);
    vtx_valid = 1'b1; step();
    check("b2b_out_valid", vtx_out_valid, 1);
    check("b2b_count",     vtx_txn_count, 0);
    check("b2b_cen",       vtx_mem_cen,   0);
    check("b2b_addr",      vtx_mem_addr,  0);
    check("b2b_proto",     vtx_proto_err, 0);

    // Outstanding transaction spans a retire and belongs to the next window.
    req(1'b0, 32'h20, 32'h0, 4'hF); step();
    vtx_valid = 1'b1; step();
    check("span1_count", vtx_txn_count, 0);
    check("span1_valid", vtx_out_valid, 1);
    rsp(32'h55, 1'b0); step();
    check("span_idle_valid", vtx_out_valid, 0);
    vtx_valid = 1'b1; step();
    check("span2_count", vtx_txn_count, 1);
    check("span2_addr",  vtx_mem_addr,  32'h20);
    check("span2_rdata", vtx_mem_rdata, 32'h55);
    check("span2_cen",   vtx_mem_cen,   4'b0001);

    // Response with nothing outstanding: sticky protocol error.
    rsp(32'h99, 1'b0); step();
    check("perr_set", vtx_proto_err, 1);
    vtx_valid = 1'b1; step();
    check("perr_ret_count", vtx_txn_count, 0);
    check("perr_sticky1",   vtx_proto_err, 1);
    step(); step();
    check("perr_sticky2",   vtx_proto_err, 1);

    // Reset mid-transaction with two committed in the working buffer.
    req(1'b0, 32'h40, 32'h0, 4'hF); step();
    rsp(32'h1, 1'b0); vtx_valid = 1'b1; step();
    req(1'b0, 32'h44, 32'h0, 4'hF); step();
    rsp(32'h2, 1'b0); step();
    req(1'b0, 32'h48, 32'h0, 4'hF); step();
    rsp(32'h3, 1'b0); step();
    req(1'b0, 32'h4C, 32'h0, 4'hF); step();
    check("prerst_count", vtx_txn_count, 1);
    vtx_resetn = 1'b0;
    #1;
    check("arst_count", vtx_txn_count, 0);
    check("arst_cen",   vtx_mem_cen,   0);
    check("arst_addr",  vtx_mem_addr,  0);
    check("arst_rdata", vtx_mem_rdata, 0);
    check("arst_proto", vtx_proto_err, 0);
    check("arst_valid", vtx_out_valid, 0);
    step();
    vtx_resetn = 1'b1;
    step();
    vtx_valid = 1'b1; step();
    check("postrst_valid", vtx_out_valid, 1);
    check("postrst_count", vtx_txn_count, 0);
    check("postrst_cen",   vtx_mem_cen,   0);
    rsp(32'h7, 1'b0); step();
    check("postrst_orphan_rsp", vtx_proto_err, 1);

    // Second request while one is outstanding is ignored and flagged.
    reset_pulse();
    req(1'b1, 32'h30, 32'h1234, 4'h1); step();
    check("dup_no_err_yet", vtx_proto_err, 0);
    req(1'b1, 32'h34, 32'h5678, 4'h2); step();
    check("dup_err", vtx_proto_err, 1);
    rsp(32'h7, 1'b0); step();
    vtx_valid = 1'b1; step();
    check("dup_count", vtx_txn_count, 1);
    check("dup_addr",  vtx_mem_addr,  32'h30);
    check("dup_wdata", vtx_mem_wdata, 32'h1234);
    check("dup_ben",   vtx_mem_ben,   4'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
